double_threshold_hyst: RTL and testbench

DOUBLE_THRESHOLD_HYST -- requirements
Module: double_threshold_hyst

---
 rtl/double_threshold_hyst.sv | 154 +++++++++++++++
 tb/tb_double_threshold_hyst.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/double_threshold_hyst.sv
// Hysteresis edge linking for a raster NMS stream: pixels are classified
// NONE/WEAK/STRONG, then kept via a 3x3 class window built from two line buffers.
module double_threshold_hyst #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int HIGH_TH    = 100,
    parameter int LOW_TH     = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic       pixel_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 1);

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_WEAK   = 2'd1;
    localparam logic [1:0] CLS_STRONG = 2'd2;

    typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, out_col_q;
    logic [RW-1:0]  row_q, out_row_q;
    logic [FW-1:0]  flush_cnt_q;
    logic [1:0]     win_q [3][3];
    logic [1:0]     win_d [3][3];
    logic [1:0]     lb_a  [IMG_WIDTH];
    logic [1:0]     lb_b  [IMG_WIDTH];

    logic       accept, step, emit, flush_done, last_px;
    logic [1:0] cls_in, center;
    logic       strong_nb, keep;

    always_comb begin
        pixel_in_ready = !rst && (state_q != StFlush);
        accept         = pixel_in_valid && pixel_in_ready;
        step           = accept || (state_q == StFlush);
        emit           = step && ((state_q == StRun) || (state_q == StFlush));
        flush_done     = (state_q == StFlush) && (flush_cnt_q == FW'(IMG_WIDTH));
        last_px        = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
    end

    // Flush feeds virtual NONE pixels so the bottom line drains through the window.
    always_comb begin
        cls_in = CLS_NONE;
        if (state_q != StFlush) begin
            if (pixel_in >= 8'(HIGH_TH))     cls_in = CLS_STRONG;
            else if (pixel_in >= 8'(LOW_TH)) cls_in = CLS_WEAK;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        win_d[0][2] = lb_b[col_q];
        win_d[1][2] = lb_a[col_q];
        win_d[2][2] = cls_in;
    end

    // Border masking uses the centre position, so stale line-buffer data never leaks in.
    always_comb begin
        logic in_frame;
        strong_nb = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                in_frame = 1'b1;
                if (r == 0 && out_row_q == '0) in_frame = 1'b0;
                if (r == 2 && out_row_q == RW'(IMG_HEIGHT - 1)) in_frame = 1'b0;
                if (c == 0 && out_col_q == '0) in_frame = 1'b0;
                if (c == 2 && out_col_q == CW'(IMG_WIDTH - 1)) in_frame = 1'b0;
                if (!(r == 1 && c == 1) && in_frame && win_d[r][c] == CLS_STRONG) begin
                    strong_nb = 1'b1;
                end
            end
        end
        center = win_d[1][1];
        keep   = (center == CLS_STRONG) || ((center == CLS_WEAK) && strong_nb);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StFill;
            StFill:  if (accept && row_q == RW'(1) && col_q == '0) state_d = StRun;
            StRun:   if (accept && last_px) state_d = StFlush;
            StFlush: if (flush_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            col_q          <= '0;
            row_q          <= '0;
            out_col_q      <= '0;
            out_row_q      <= '0;
            flush_cnt_q    <= '0;
            data_out       <= 8'd0;
            data_out_valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= CLS_NONE;
                end
            end
        end else begin
            state_q        <= state_d;
            data_out_valid <= emit;
            if (emit) data_out <= keep ? 8'd255 : 8'd0;
            if (step) begin
                win_q <= win_d;
                col_q <= (col_q == CW'(IMG_WIDTH - 1)) ? '0 : col_q + 1'b1;
            end
            if (accept && col_q == CW'(IMG_WIDTH - 1)) begin
                row_q <= (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end
            if (emit) begin
                if (out_col_q == CW'(IMG_WIDTH - 1)) begin
                    out_col_q <= '0;
                    out_row_q <= (out_row_q == RW'(IMG_HEIGHT - 1)) ? '0 : out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end
            if (state_q == StFlush) flush_cnt_q <= flush_cnt_q + 1'b1;
            if (flush_done) begin
                col_q       <= '0;
                row_q       <= '0;
                out_col_q   <= '0;
                out_row_q   <= '0;
                flush_cnt_q <= '0;
            end
        end
    end

    // Line buffers are deliberately left unreset; the window masks their contents.
    always_ff @(posedge clk) begin
        if (step) begin
            lb_b[col_q] <= lb_a[col_q];
            lb_a[col_q] <= cls_in;
        end
    end

endmodule

// File: tb/tb_double_threshold_hyst.sv
// Scoreboard bench: frame-level reference model fills an expectation queue,
// a negedge monitor pops and checks every output along with its latency.
module tb_double_threshold_hyst;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_in;
    logic       pixel_in_valid;
    logic       pixel_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;

    double_threshold_hyst #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .HIGH_TH   (100),
        .LOW_TH    (50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_in      (pixel_in),
        .pixel_in_valid(pixel_in_valid),
        .pixel_in_ready(pixel_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         acc = 0;
    int         out_total = 0;
    logic [7:0] last_out = 8'd0;
    int         frame[N];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cls(input int v);
        if (v >= 100) return 2;
        if (v >= 50) return 1;
        return 0;
    endfunction

    // Direct statement of the hysteresis rule on the whole frame.
    function automatic logic [7:0] ref_px(input int r, input int c);
        int ctr;
        bit sn;
        ctr = cls(frame[r*W + c]);
        sn = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                    if (cls(frame[(r+dr)*W + c + dc]) == 2) sn = 1;
            end
        end
        return (ctr == 2 || (ctr == 1 && sn)) ? 8'd255 : 8'd0;
    endfunction

    task automatic model_push(input int n_out);
        for (int k = 0; k < n_out; k++) exp_q.push_back(ref_px(k / W, k % W));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            acc = 0;
            out_total = 0;
            last_out = 8'd0;
        end else begin
            if (data_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0d expected none", data_out);
                end else begin
                    int k, f, need;
                    k = out_total % N;
                    f = out_total / N;
                    need = (k + W + 2 < N) ? k + W + 2 : N;
                    check("data", data_out, exp_q.pop_front());
                    check("latency_accepted", acc, f * N + need);
                    out_total++;
                    last_out = data_out;
                end
            end else begin
                check("hold_data", data_out, last_out);
            end
            if (pixel_in_valid && pixel_in_ready) acc++;
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        pixel_in = v;
        pixel_in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pixel_in_ready) break;
            n++;
            if (n > 50) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 every other cycle, 2 random gaps
    task automatic run_frame(input int gap_mode);
        int lowc, g, n;
        model_push(N);
        for (int i = 0; i < N; i++) begin
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send(8'(frame[i]));
        end
        lowc = 0;
        forever begin
            @(negedge clk);
            if (pixel_in_ready || lowc > 100) break;
            lowc++;
        end
        check("flush_ready_low", lowc, W + 1);
        @(posedge clk);
        #1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        @(negedge clk);
        check("ready_in_reset", pixel_in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", pixel_in_ready, 1);
        check("reset_valid", data_out_valid, 0);
        check("reset_data", data_out, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) frame[i] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[8];
        vals = '{0, 30, 49, 50, 99, 100, 120, 255};
        rst = 1'b1;
        pixel_in = 8'd0;
        pixel_in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        fill(120);
        run_frame(0);

        fill(60);
        frame[1*W + 1] = 150;
        run_frame(0);

        fill(0);
        frame[1*W + 3] = 150;
        frame[2*W + 0] = 60;
        run_frame(0);

        fill(0);
        frame[0*W + 0] = 49;
        frame[0*W + 2] = 50;
        frame[2*W + 0] = 99;
        frame[2*W + 2] = 100;
        run_frame(0);

        for (int i = 0; i < N; i++) frame[i] = vals[$urandom_range(0, 7)];
        run_frame(0);
        run_frame(1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) frame[i] = vals[$urandom_range(0, 7)];
            run_frame(t % 3);
        end

        // Abort a frame after 7 pixels; only outputs for k = 0,1 precede the reset.
        fill(120);
        model_push(7 - W - 1);
        for (int i = 0; i < 7; i++) send(8'd120);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_pending", exp_q.size(), 0);
        check("abort_ready_low", pixel_in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(0);
        check("abort_total_outputs", out_total, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
